axi_req_arbiter: RTL and testbench

Parametrised N-port arbiter that converts simple cached/uncached request/acknowledge ports (instruction fetch, data load/store, and any further requesters) into transactions on one 32-bit AXI3 master. It sits between the CPU-side MMU/cache request ports and the SoC AXI interconnect. It generalises the fixed two-client bridging to N requesters with burst reads and per-port error reporting. One transaction is outstanding at a time.

---
 rtl/axi_req_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_req_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_req_arbiter.sv
// N-port request/acknowledge to single-outstanding AXI3 master bridge with burst reads.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (port 0 highest).
module axi_req_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ID_W    = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_PORTS-1:0]     req_valid,
  output logic [N_PORTS-1:0]     req_ready,
  input  logic [N_PORTS-1:0]     req_wen,
  input  logic [N_PORTS*32-1:0]  req_addr,
  input  logic [N_PORTS*3-1:0]   req_size,
  input  logic [N_PORTS*8-1:0]   req_len,
  input  logic [N_PORTS*32-1:0]  req_wdata,
  input  logic [N_PORTS*4-1:0]   req_wstrb,
  output logic [N_PORTS-1:0]     resp_valid,
  output logic                   resp_last,
  output logic                   resp_err,
  output logic [31:0]            resp_rdata,
  output logic [ID_W-1:0]        arid,
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [ID_W-1:0]        rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [ID_W-1:0]        awid,
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [ID_W-1:0]        wid,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [ID_W-1:0]        bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP} state_t;

  state_t               r_state;
  logic [GW-1:0]        r_grant;
  logic [31:0]          r_addr;
  logic [2:0]           r_size;
  logic [7:0]           r_len;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic                 r_arvalid;
  logic                 r_awvalid;
  logic                 r_wvalid;
  logic [N_PORTS-1:0]   r_respValid;
  logic                 r_respLast;
  logic                 r_respErr;
  logic [31:0]          r_respRdata;
  logic [GW-1:0]        w_winner;
  logic                 w_accept;
  logic                 w_unused;

  assign w_accept  = (r_state == IDLE) && (|req_valid);
  assign req_ready = w_accept ? (N_PORTS'(1) << w_winner) : '0;

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0] r_lastGrant;

  // Descending scan so the port closest after the last grant is assigned last and wins.
  always_comb begin
    w_winner = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_lastGrant) + 1 + k) % N_PORTS])
        w_winner = GW'((int'(r_lastGrant) + 1 + k) % N_PORTS);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)
      r_lastGrant <= '0;
    else if (w_accept)
      r_lastGrant <= w_winner;
  end
`else
  always_comb begin
    w_winner = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req_valid[k])
        w_winner = GW'(k);
    end
  end
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_addr      <= '0;
      r_size      <= '0;
      r_len       <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_arvalid   <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_respValid <= '0;
      r_respLast  <= 1'b0;
      r_respErr   <= 1'b0;
      r_respRdata <= '0;
    end else begin
      r_respValid <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_grant <= w_winner;
            r_addr  <= req_addr[w_winner*32 +: 32];
            r_size  <= req_size[w_winner*3 +: 3];
            r_len   <= req_len[w_winner*8 +: 8];
            r_wdata <= req_wdata[w_winner*32 +: 32];
            r_wstrb <= req_wstrb[w_winner*4 +: 4];
            if (req_wen[w_winner]) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WRITE;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RADDR;
            end
          end
        end
        RADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_state   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid) begin
            r_respValid <= N_PORTS'(1) << r_grant;
            r_respRdata <= rdata;
            r_respErr   <= (rresp != 2'b00);
            r_respLast  <= rlast;
            if (rlast)
              r_state <= IDLE;
          end
        end
        // The AW and W valids double as the done flags, so either order or both at once works.
        WRITE: begin
          if (awready)
            r_awvalid <= 1'b0;
          if (wready)
            r_wvalid <= 1'b0;
          if ((!r_awvalid || awready) && (!r_wvalid || wready))
            r_state <= WRESP;
        end
        WRESP: begin
          if (bvalid) begin
            r_respValid <= N_PORTS'(1) << r_grant;
            r_respErr   <= (bresp != 2'b00);
            r_respLast  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign arid    = ID_W'(r_grant);
  assign araddr  = r_addr;
  assign arlen   = r_len;
  assign arsize  = r_size;
  assign arburst = (r_len != 8'd0) ? 2'd2 : 2'd1;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = r_arvalid;
  assign rready  = (r_state == RDATA);

  assign awid    = ID_W'(r_grant);
  assign awaddr  = r_addr;
  assign awlen   = 8'd0;
  assign awsize  = r_size;
  assign awburst = 2'd1;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = r_awvalid;
  assign wid     = ID_W'(r_grant);
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = (r_state == WRESP);

  assign resp_valid = r_respValid;
  assign resp_last  = r_respLast;
  assign resp_err   = r_respErr;
  assign resp_rdata = r_respRdata;

  // Response IDs are deliberately ignored; only one transaction is ever in flight.
  assign w_unused = ^{rid, bid};

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Randomized bench for axi_req_arbiter: random requesters and AXI slave against a transaction-level model.
// Follows ARB_ROUND_ROBIN_EN the same way the design does.
module tb_axi_req_arbiter;

  localparam int NP  = 3;
  localparam int IDW = 4;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NP-1:0]     req_valid, req_ready, req_wen, resp_valid;
  logic [NP*32-1:0]  req_addr, req_wdata;
  logic [NP*3-1:0]   req_size;
  logic [NP*8-1:0]   req_len;
  logic [NP*4-1:0]   req_wstrb;
  logic              resp_last, resp_err;
  logic [31:0]       resp_rdata;
  logic [IDW-1:0]    arid, rid, awid, wid, bid;
  logic [31:0]       araddr, rdata, awaddr, wdata;
  logic [7:0]        arlen, awlen;
  logic [2:0]        arsize, arprot, awsize, awprot;
  logic [1:0]        arburst, arlock, rresp, awburst, awlock, bresp;
  logic [3:0]        arcache, awcache, wstrb;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_req_arbiter #(.N_PORTS(NP), .ID_W(IDW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_last(resp_last), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          port;
    logic        wen;
    logic [31:0] addr;
    int          size;
    int          len;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  int          checks = 0;
  int          failures = 0;
  txn_t        portReq [NP];
  logic [NP-1:0] accepted;
  txn_t        cur;
  logic        busy, arDone, awDone, wDone;
  int          beat, lastGrant, completed, midResets;
  logic        respPending, respIsRead, respErrExp, respLastExp, justReset, resetReq, contention;
  int          respPort;
  logic [31:0] respData;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Arbitration rule: fixed lowest index, or round-robin scan starting after the last grant.
  function automatic int pickWinner(input logic [NP-1:0] v);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (lastGrant + k) % NP;
      if (v[p]) return p;
    end
`else
    for (int p = 0; p < NP; p++)
      if (v[p]) return p;
`endif
    return -1;
  endfunction

  task automatic resetModel();
    busy = 1'b0; arDone = 1'b0; awDone = 1'b0; wDone = 1'b0;
    beat = 0; lastGrant = 0; respPending = 1'b0; accepted = '0;
  endtask

  // Registered outputs reflect the handshakes the model recorded at the previous edge.
  task automatic checkRegistered();
    logic [NP-1:0] expRespValid;
    expRespValid = respPending ? (NP'(1) << respPort) : '0;
    checkOutput("resp_valid", 32'(resp_valid), 32'(expRespValid));
    if (respPending) begin
      checkOutput("resp_last", 32'(resp_last), 32'(respLastExp));
      checkOutput("resp_err", 32'(resp_err), 32'(respErrExp));
      if (respIsRead) checkOutput("resp_rdata", resp_rdata, respData);
    end
    if (justReset) begin
      checkOutput("rst_rdata", resp_rdata, 32'h0);
      checkOutput("rst_err_last", 32'({resp_err, resp_last}), 32'h0);
      justReset = 1'b0;
    end
    checkOutput("arvalid", 32'(arvalid), 32'(busy && !cur.wen && !arDone));
    checkOutput("rready", 32'(rready), 32'(busy && !cur.wen && arDone));
    checkOutput("awvalid", 32'(awvalid), 32'(busy && cur.wen && !awDone));
    checkOutput("wvalid", 32'(wvalid), 32'(busy && cur.wen && !wDone));
    checkOutput("bready", 32'(bready), 32'(busy && cur.wen && awDone && wDone));
    if (busy && !cur.wen && !arDone) begin
      checkOutput("arid", 32'(arid), cur.port);
      checkOutput("araddr", araddr, cur.addr);
      checkOutput("arlen", 32'(arlen), cur.len);
      checkOutput("arsize", 32'(arsize), cur.size);
      checkOutput("arburst", 32'(arburst), (cur.len != 0) ? 32'd2 : 32'd1);
      checkOutput("ar_const", 32'({arlock, arcache, arprot}), 32'h0);
    end
    if (busy && cur.wen && !awDone) begin
      checkOutput("awid", 32'(awid), cur.port);
      checkOutput("awaddr", awaddr, cur.addr);
      checkOutput("awlen", 32'(awlen), 32'h0);
      checkOutput("awsize", 32'(awsize), cur.size);
    end
    if (busy && cur.wen && !wDone) begin
      checkOutput("wid", 32'(wid), cur.port);
      checkOutput("wdata", wdata, cur.wdata);
      checkOutput("wstrb", 32'(wstrb), 32'(cur.wstrb));
      checkOutput("wlast", 32'(wlast), 32'h1);
    end
  endtask

  // Drives requesters and the AXI slave for the coming rising edge.
  task automatic applyStimulus(input int cycle);
    contention = (cycle >= 2000 && cycle < 2600);
    resetReq = (cycle < 2) ||
               (busy && !cur.wen && cur.len >= 7 && beat == 3 && midResets < 4 &&
                $urandom_range(0, 1) == 1);
    if (resetReq && cycle >= 2) midResets++;
    aresetn = !resetReq;
    for (int i = 0; i < NP; i++) begin
      if (resetReq || accepted[i]) req_valid[i] = 1'b0;
      else if (req_valid[i] && !contention && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      if (!resetReq && !req_valid[i] &&
          (contention ? (i < 2) : ($urandom_range(0, 3) == 0))) begin
        int r;
        r = int'($urandom_range(0, 9));
        req_valid[i]       = 1'b1;
        portReq[i].port    = i;
        portReq[i].wen     = ($urandom_range(0, 2) == 0);
        portReq[i].addr    = $urandom;
        portReq[i].size    = int'($urandom_range(0, 2));
        portReq[i].len     = (r < 6) ? int'($urandom_range(0, 3)) : ((r < 9) ? 7 : 15);
        portReq[i].wdata   = $urandom;
        portReq[i].wstrb   = 4'($urandom_range(1, 15));
      end
      req_wen[i]              = portReq[i].wen;
      req_addr[i*32 +: 32]    = portReq[i].addr;
      req_size[i*3 +: 3]      = 3'(portReq[i].size);
      req_len[i*8 +: 8]       = 8'(portReq[i].len);
      req_wdata[i*32 +: 32]   = portReq[i].wdata;
      req_wstrb[i*4 +: 4]     = portReq[i].wstrb;
    end
    arready = !resetReq && ($urandom_range(0, 1) == 1);
    rvalid  = !resetReq && busy && !cur.wen && arDone && ($urandom_range(0, 2) != 0);
    rdata   = $urandom;
    rresp   = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0;
    rlast   = rvalid && (beat == cur.len);
    rid     = IDW'($urandom_range(0, 15));
    awready = !resetReq && ($urandom_range(0, 4) < 2);
    wready  = !resetReq && ($urandom_range(0, 4) < 2);
    bvalid  = !resetReq && busy && cur.wen && awDone && wDone && ($urandom_range(0, 4) < 3);
    bresp   = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0;
    bid     = IDW'($urandom_range(0, 15));
  endtask

  // Evaluates the handshakes that the coming edge will perform and advances the model.
  task automatic updateModel();
    logic [NP-1:0] expReady;
    int w;
    expReady = '0;
    w = pickWinner(req_valid);
    if (!busy && w >= 0) expReady[w] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    accepted = req_valid & req_ready;
    respPending = 1'b0;
    if (resetReq) begin
      resetModel();
      justReset = 1'b1;
    end else if (!busy) begin
      if (w >= 0) begin
        cur = portReq[w];
        cur.port = w;
        busy = 1'b1; arDone = 1'b0; awDone = 1'b0; wDone = 1'b0; beat = 0;
        lastGrant = w;
      end
    end else if (!cur.wen) begin
      if (!arDone) begin
        if (arready) arDone = 1'b1;
      end else if (rvalid) begin
        respPending = 1'b1; respIsRead = 1'b1; respPort = cur.port;
        respData = rdata; respErrExp = (rresp != 2'd0); respLastExp = (beat == cur.len);
        beat++;
        if (respLastExp) begin busy = 1'b0; completed++; end
      end
    end else begin
      if (awDone && wDone) begin
        if (bvalid) begin
          respPending = 1'b1; respIsRead = 1'b0; respPort = cur.port;
          respErrExp = (bresp != 2'd0); respLastExp = 1'b1;
          busy = 1'b0; completed++;
        end
      end else begin
        if (!awDone && awready) awDone = 1'b1;
        if (!wDone && wready) wDone = 1'b1;
      end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    req_valid = '0; req_wen = '0; req_addr = '0; req_size = '0; req_len = '0;
    req_wdata = '0; req_wstrb = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    for (int i = 0; i < NP; i++) begin
      portReq[i].port = i; portReq[i].wen = 1'b0; portReq[i].addr = '0; portReq[i].size = 0;
      portReq[i].len = 0; portReq[i].wdata = '0; portReq[i].wstrb = '0;
    end
    cur = portReq[0];
    completed = 0; midResets = 0; justReset = 1'b1; resetReq = 1'b1; contention = 1'b0;
    respIsRead = 1'b0; respErrExp = 1'b0; respLastExp = 1'b0; respPort = 0; respData = '0;
    resetModel();
    for (int cycle = 0; cycle < 6000; cycle++) begin
      @(negedge aclk);
      checkRegistered();
      applyStimulus(cycle);
      #1;
      updateModel();
    end
    checkOutput("progress", 32'(completed > 100), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
